pe_cmd_seq: RTL and testbench
=============================

# pe_cmd_seq

Command sequencer for the simple PE. Buffers host commands (direct register writes, PE arithmetic ops, register reads) in a FIFO and replays them onto the PE's cfg bus with the two-cycle write protocol the PE requires: cfg inputs are latched on one edge, and the register file commits on the next edge while sampling cfg_wdata directly. Reads are returned on a valid/ready response port. The block sits between the host/config interconnect and a single PE instance.

## Interface
- FIFO_DEPTH, 8: command FIFO entries, power of two, at least 2.
- CNT_W, 16: width of the completed-command counter.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_kind  in  2  0 = direct write, 1 = PE op, 2 = read, 3 = reserved (accepted, then dropped).
- cmd_addr  in  32  PE instruction/address word: opcode[31:25], func[24:20], rs1[19:15], rs2[14:10], rs3[9:5], rd[4:0].
- cmd_wdata  in  32  write data (direct write only).
- rsp_valid / rsp_ready  out/in  1  read response handshake.
- rsp_data  out  32  read data.
- pe_cfg_addr, pe_cfg_wdata  out  32  to PE.
- pe_cfg_we, pe_cfg_en  out  1  to PE.
- pe_cfg_rdata  in  32  from PE; combinational function of pe_cfg_addr[4:0].
- busy  out  1  FSM not IDLE or FIFO non-empty.
- done_irq  out  1  one-cycle pulse on busy falling edge.
- op_count  out  CNT_W  completed commands; wraps to 0.
- err  out  1  sticky illegal-op flag (only with macro; otherwise tied 0).
- err_clr  in  1  clears err.

## Operation
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and load the pe_cfg registers. Writes and ops go to DRIVE, reads go to RD, kind 3 is dropped (stay in IDLE, counted).
  - DRIVE: pe_cfg_we = 1. pe_cfg_en = 1 for a PE op, 0 for a direct write. addr/wdata hold the command. Always goes to HOLD.
  - HOLD: we = en = 0, addr/wdata unchanged. Increments op_count. If the FIFO is non-empty, pops the next command (same dispatch as IDLE); otherwise goes to IDLE.
  - RD: we = en = 0, pe_cfg_addr = cmd_addr. At the end edge, pe_cfg_rdata is captured into rsp_data, rsp_valid is set, and the FSM goes to RSP.
  - RSP: hold rsp_valid and rsp_data until rsp_ready. On the handshake, clear rsp_valid, increment op_count, then pop the next command or go to IDLE.
- The FIFO is only popped from IDLE, HOLD, and RSP-with-handshake. There is no bypass: a push into an empty FIFO is visible one cycle later.
- A write or op to rd = 0 is issued normally (the PE ignores it) and is counted.
- busy is computed combinationally. done_irq is registered from busy, high for exactly one cycle.
- err_clr has priority over a simultaneous set.

## Timing
- Reset values: all pe_cfg_* = 0, rsp_valid = 0, rsp_data = 0, op_count = 0, err = 0, done_irq = 0, FIFO empty, state IDLE.
- Accept at edge 0 with FSM idle:
  - pop at edge 1;
  - pe_cfg_we high between edges 1 and 2 (PE latches at edge 2);
  - HOLD between edges 2 and 3 (PE commits at edge 3).
- Write/op throughput is 1 per 2 cycles. Reads take at least 2 cycles (RD, then RSP).
- A read following a write: the RD state begins at edge 3, after the commit, so the read returns the new value. No extra hazard stall is needed.
- With rsp_ready held low, RSP stalls indefinitely. No PE activity occurs and the FIFO keeps filling until cmd_ready drops.
- Asserting rst_n mid-DRIVE/HOLD aborts immediately: outputs go to reset values and queued commands are lost.

## Configuration
- PE_SEQ_ILLEGAL_CHK_EN defined: a kind-1 command is checked before dispatch. If opcode ≠ 7'b0000001 or func is not in {1, 2, 3}, it is dropped without being driven to the PE, err is set, and op_count is not incremented.
- PE_SEQ_ILLEGAL_CHK_EN undefined: all kind-1 commands are forwarded (the PE writes 0 to rd for unknown ops), and err is constant 0.

## Structure
- pe_seq_pkg holds:
  - cmd kind encodings;
  - PE opcode/func constants (OPC_ARITH, FUNC_ADD/SUB/MUL);
  - field bit positions;
  - FSM state enum.
- Sub-module pe_seq_fifo: synchronous FIFO (push/pop/full/empty, width 66) instantiated once.

## Test plan
- Write r1 = 5, write r2 = 7, op ADD with cmd_addr = 0x02108803, read r3 → rsp_data = 12, op_count = 4, one done_irq pulse.
- Same setup with func = 3 (MUL, cmd_addr = 0x02308803) → read r3 = 35. With func = 2 (SUB, r1 − r2) → 0xFFFFFFFE.
- Push 9 commands with rsp_ready = 0 and a read first → cmd_ready low after 8 queued, and pe_cfg_we never asserts while stalled in RSP.
- Write r0 = 0x55, then read r0 → rsp_data = 0, op_count = 2.
- With PE_SEQ_ILLEGAL_CHK_EN: op with opcode 0000010 → pe_cfg_we stays 0, err = 1. err_clr → err = 0.
- Reset asserted in HOLD of a write to r4 → all outputs return to reset values and busy = 0. A following read of r4 (PE also reset) → 0.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the PE command sequencer.
// Command kinds, PE instruction layout, arithmetic op encodings and FSM states.
package pe_seq_pkg;

  localparam int FIFO_W = 66;

  typedef enum logic [1:0] {
    KIND_WRITE = 2'd0,
    KIND_OP    = 2'd1,
    KIND_READ  = 2'd2,
    KIND_RSVD  = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_HOLD,
    ST_RD,
    ST_RSP
  } seq_state_e;

  // Field positions of the PE instruction word, MSB first.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] func;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [4:0] rd;
  } pe_instr_t;

  localparam logic [6:0] OPC_ARITH = 7'b0000001;
  localparam logic [4:0] FUNC_ADD  = 5'd1;
  localparam logic [4:0] FUNC_SUB  = 5'd2;
  localparam logic [4:0] FUNC_MUL  = 5'd3;

  function automatic logic op_is_legal(input logic [31:0] word);
    pe_instr_t ins;
    ins = pe_instr_t'(word);
    return (ins.opcode == OPC_ARITH) &&
           (ins.func == FUNC_ADD || ins.func == FUNC_SUB || ins.func == FUNC_MUL);
  endfunction

endpackage

// File: rtl/pe_seq_fifo.sv
// Synchronous command FIFO; a push into an empty FIFO becomes visible one cycle later.
// DEPTH must be a power of two, at least 2.
module pe_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pe_cmd_seq.sv
// Command sequencer: queues host commands and replays them onto the PE cfg bus.
// Build macro PE_SEQ_ILLEGAL_CHK_EN: drop malformed PE ops before dispatch and raise err.
//
// state    | meaning
// ST_IDLE  | waiting; pops and dispatches the FIFO head when present
// ST_DRIVE | cfg_we high, PE latches the command at the end edge
// ST_HOLD  | cfg bus held, PE commits; may dispatch the next command
// ST_RD    | cfg_addr presents read address, rdata captured at end edge
// ST_RSP   | response held until rsp_ready; may dispatch the next command
module pe_cmd_seq
  import pe_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [31:0]      pe_cfg_addr,
  output logic [31:0]      pe_cfg_wdata,
  output logic             pe_cfg_we,
  output logic             pe_cfg_en,
  input  logic [31:0]      pe_cfg_rdata,
  output logic             busy,
  output logic             done_irq,
  output logic [CNT_W-1:0] op_count,
  output logic             err,
  input  logic             err_clr
);

  seq_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_op_q, is_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  op_count_q;
  logic [1:0]        cnt_inc;
  logic              busy_q, done_irq_q;
  logic              dispatch, legal;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  cmd_kind_e         head_kind;
  logic [31:0]       head_addr, head_wdata;

  assign fifo_push  = cmd_valid && !fifo_full;
  assign fifo_wdata = {cmd_kind, cmd_addr, cmd_wdata};
  assign cmd_ready  = !fifo_full;
  assign head_kind  = cmd_kind_e'(fifo_rdata[65:64]);
  assign head_addr  = fifo_rdata[63:32];
  assign head_wdata = fifo_rdata[31:0];

  pe_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef PE_SEQ_ILLEGAL_CHK_EN
  logic err_q, err_set;

  // Clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_clr) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_op_d     = is_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;
    cnt_inc     = 2'd0;
    dispatch    = 1'b0;
    legal       = 1'b1;
    pe_cfg_we   = 1'b0;
    pe_cfg_en   = 1'b0;
`ifdef PE_SEQ_ILLEGAL_CHK_EN
    err_set     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: dispatch = 1'b1;
      ST_DRIVE: begin
        pe_cfg_we = 1'b1;
        pe_cfg_en = is_op_q;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_inc  = 2'd1;
        dispatch = 1'b1;
      end
      ST_RD: begin
        rsp_data_d  = pe_cfg_rdata;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_inc     = 2'd1;
          dispatch    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared pop/dispatch path for IDLE, HOLD and RSP handshake.
    if (dispatch) begin
      state_d = ST_IDLE;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        case (head_kind)
          KIND_WRITE, KIND_OP: begin
`ifdef PE_SEQ_ILLEGAL_CHK_EN
            legal   = (head_kind != KIND_OP) || op_is_legal(head_addr);
            err_set = !legal;
`endif
            if (legal) begin
              state_d = ST_DRIVE;
              addr_d  = head_addr;
              wdata_d = head_wdata;
              is_op_d = (head_kind == KIND_OP);
            end
          end
          KIND_READ: begin
            state_d = ST_RD;
            addr_d  = head_addr;
          end
          default: cnt_inc = cnt_inc + 2'd1;
        endcase
      end
    end
  end

  assign busy = (state_q != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_op_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
      done_irq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_op_q     <= is_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_q + CNT_W'(cnt_inc);
      busy_q      <= busy;
      done_irq_q  <= busy_q && !busy;
    end
  end

  assign pe_cfg_addr  = addr_q;
  assign pe_cfg_wdata = wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign op_count     = op_count_q;
  assign done_irq     = done_irq_q;

endmodule

// File: tb/tb_pe_cmd_seq.sv
// Bench for pe_cmd_seq: behavioural PE, command-level reference model, directed and random traffic.
`timescale 1ns/1ps
module tb_pe_cmd_seq;

  localparam int DEPTH = 8;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_kind = 2'd0;
  logic [31:0]   cmd_addr = 32'd0;
  logic [31:0]   cmd_wdata = 32'd0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [31:0]   pe_cfg_addr, pe_cfg_wdata, pe_cfg_rdata;
  logic          pe_cfg_we, pe_cfg_en;
  logic          busy, done_irq, err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  pe_cmd_seq #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_kind     (cmd_kind),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .pe_cfg_addr  (pe_cfg_addr),
    .pe_cfg_wdata (pe_cfg_wdata),
    .pe_cfg_we    (pe_cfg_we),
    .pe_cfg_en    (pe_cfg_en),
    .pe_cfg_rdata (pe_cfg_rdata),
    .busy         (busy),
    .done_irq     (done_irq),
    .op_count     (op_count),
    .err          (err),
    .err_clr      (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    if (ins[31:25] != 7'd1) return 32'd0;
    case (ins[24:20])
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // PE: latches cfg on one edge, commits on the next using the live cfg_wdata.
  logic [31:0] pe_regs [32];
  logic [31:0] pe_lat_addr;
  logic        pe_lat_we, pe_lat_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) pe_regs[i] <= 32'd0;
      pe_lat_addr <= 32'd0;
      pe_lat_we   <= 1'b0;
      pe_lat_en   <= 1'b0;
    end else begin
      if (pe_lat_we && pe_lat_addr[4:0] != 5'd0)
        pe_regs[pe_lat_addr[4:0]] <= pe_lat_en ?
          alu(pe_lat_addr, pe_regs[pe_lat_addr[19:15]], pe_regs[pe_lat_addr[14:10]]) : pe_cfg_wdata;
      pe_lat_addr <= pe_cfg_addr;
      pe_lat_we   <= pe_cfg_we;
      pe_lat_en   <= pe_cfg_en;
    end
  end
  assign pe_cfg_rdata = pe_regs[pe_cfg_addr[4:0]];

  // Command-level reference: commands take effect in acceptance order.
  logic [31:0]   ref_regs [32];
  logic [31:0]   exp_q [$];
  logic [CW-1:0] exp_cnt;
  logic          exp_err;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    exp_q.delete();
    exp_cnt = '0;
    exp_err = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    logic [4:0] rd;
    logic       legal;
    rd = a[4:0];
    legal = (a[31:25] == 7'd1) && (a[24:20] >= 5'd1) && (a[24:20] <= 5'd3);
    case (k)
      2'd0: begin
        if (rd != 5'd0) ref_regs[rd] = d;
        exp_cnt = exp_cnt + 1'b1;
      end
      2'd1: begin
`ifdef PE_SEQ_ILLEGAL_CHK_EN
        if (!legal) exp_err = 1'b1;
        else begin
`else
        begin
          if (legal) ;
`endif
          if (rd != 5'd0) ref_regs[rd] = alu(a, ref_regs[a[19:15]], ref_regs[a[14:10]]);
          exp_cnt = exp_cnt + 1'b1;
        end
      end
      2'd2: begin
        exp_q.push_back(ref_regs[rd]);
        exp_cnt = exp_cnt + 1'b1;
      end
      default: exp_cnt = exp_cnt + 1'b1;
    endcase
  endtask

  // Response ready: fixed level or random per cycle.
  logic rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  int          we_cnt = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  logic [31:0] last_rsp = 32'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_cfg_we) we_cnt++;
      if (done_irq) done_cnt++;
      if (rsp_valid && pe_cfg_we) stall_viol++;
      if (rsp_valid && rsp_ready) begin
        last_rsp = rsp_data;
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rsp_data", rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_addr  = a;
    cmd_wdata = d;
    t = 0;
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("push_timeout", 32'(cmd_ready), 32'd1);
    else model_apply(k, a, d);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || rsp_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, 32'(busy || rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic arith_test(input string tag, input logic [31:0] op, input logic [31:0] expv);
    logic [CW-1:0] c0, dc;
    int d0;
    c0 = op_count;
    d0 = done_cnt;
    push(2'd0, 32'd1, 32'd5);
    push(2'd0, 32'd2, 32'd7);
    push(2'd1, op, 32'd0);
    push(2'd2, 32'd3, 32'd0);
    wait_idle(tag);
    dc = op_count - c0;
    chk({tag, "_r3"}, last_rsp, expv);
    chk({tag, "_cnt"}, 32'(dc), 32'd4);
    chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c0, dc;
    int w0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_addr", pe_cfg_addr, 32'd0);
    chk("rst_wdata", pe_cfg_wdata, 32'd0);
    chk("rst_we_en", {30'd0, pe_cfg_we, pe_cfg_en}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_flags", {29'd0, busy, done_irq, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    arith_test("add", 32'h02108803, 32'd12);
    arith_test("mul", 32'h02308803, 32'd35);
    arith_test("sub", 32'h02208803, 32'hFFFFFFFE);

    c0 = op_count;
    push(2'd0, 32'd0, 32'h55);
    push(2'd2, 32'd0, 32'd0);
    wait_idle("r0");
    dc = op_count - c0;
    chk("r0_read", last_rsp, 32'd0);
    chk("r0_cnt", 32'(dc), 32'd2);

    // Read stalls in RSP while the FIFO fills.
    rdy_fixed = 1'b0;
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    push(2'd2, 32'd1, 32'd0);
    for (int i = 0; i < 8; i++) push(2'd0, 32'(i + 8), $urandom);
    @(negedge clk);
    chk("stall_ready", 32'(cmd_ready), 32'd0);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (20) @(negedge clk);
    chk("stall_no_we", 32'(we_cnt - w0), 32'd0);
    rdy_fixed = 1'b1;
    wait_idle("stall");
    chk("stall_drain_cnt", 32'(op_count), 32'(exp_cnt));

    // Unknown opcode.
    w0 = we_cnt;
    c0 = op_count;
    push(2'd1, {7'b0000010, 5'd1, 5'd1, 5'd2, 5'd0, 5'd5}, 32'd0);
    wait_idle("illegal");
    dc = op_count - c0;
`ifdef PE_SEQ_ILLEGAL_CHK_EN
    chk("illegal_no_we", 32'(we_cnt - w0), 32'd0);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_cnt", 32'(dc), 32'd0);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(err), 32'd0);
`else
    chk("fwd_we", 32'(we_cnt - w0), 32'd1);
    chk("fwd_err", 32'(err), 32'd0);
    chk("fwd_cnt", 32'(dc), 32'd1);
    push(2'd2, 32'd5, 32'd0);
    wait_idle("fwd_rd");
    chk("fwd_r5", last_rsp, 32'd0);
`endif

    // First-command latency, then reset during HOLD.
    push(2'd0, 32'd4, 32'hAB);
    @(negedge clk);
    chk("lat_pre_we", 32'(pe_cfg_we), 32'd0);
    @(negedge clk);
    chk("lat_drive_we", {30'd0, pe_cfg_we, pe_cfg_en}, 32'd2);
    chk("lat_drive_addr", pe_cfg_addr, 32'd4);
    chk("lat_drive_wdata", pe_cfg_wdata, 32'hAB);
    @(negedge clk);
    chk("lat_hold", {30'd0, pe_cfg_we, busy}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_addr", pe_cfg_addr, 32'd0);
    chk("abort_wdata", pe_cfg_wdata, 32'd0);
    chk("abort_flags", {26'd0, pe_cfg_we, pe_cfg_en, rsp_valid, busy, done_irq, err}, 32'd0);
    chk("abort_rsp", rsp_data, 32'd0);
    chk("abort_cnt", 32'(op_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(2'd2, 32'd4, 32'd0);
    wait_idle("abort_rd");
    chk("abort_r4", last_rsp, 32'd0);

    // Random traffic with random response back-pressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 120; i++) begin
      int          r;
      logic [1:0]  k;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      k = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = {7'd1, 5'($urandom_range(1, 3)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'd0, 5'($urandom_range(0, 7))};
      if (k == 2'd1 && $urandom_range(0, 5) == 0) begin
        a[31:25] = 7'($urandom_range(0, 3));
        a[24:20] = 5'($urandom_range(0, 6));
      end
      push(k, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand");
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;
    chk("rand_cnt", 32'(op_count), 32'(exp_cnt));
    chk("rand_err", 32'(err), 32'(exp_err));
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_stall_we", 32'(stall_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
